// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - burst reader from a sync BRAM port into a 3-deep output stream; BRAM_READER_ABORT_EN adds abort_i
module bram_stream_reader #(
    parameter int DataWidth = 8,
    parameter int Depth     = 1024,
    localparam int AW       = $clog2(Depth) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AW-1:0]        base_addr_i,
    input  logic [AW:0]          length_i,
    output logic [AW-1:0]        mem_addr_o,
    output logic                 mem_write_en_o,
    input  logic [DataWidth-1:0] mem_data_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 last_o,
    output logic                 busy_o,
`ifdef BRAM_READER_ABORT_EN
    input  logic                 abort_i,
`endif
    output logic                 done_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [AW:0]          issue_left_q, issue_left_d;   // reads not yet issued
    logic [AW:0]          out_left_q, out_left_d;       // words not yet transferred
    logic                 issued_q, issued_d;           // mem_addr_o holds a fresh read this cycle
    logic                 inflight_q, inflight_d;       // mem_data_i carries read data this cycle
    logic                 done_q, done_d;
    logic [DataWidth-1:0] fifo_q [3];
    logic [1:0]           rd_ptr_q, rd_ptr_d;
    logic [1:0]           wr_ptr_q, wr_ptr_d;
    logic [1:0]           count_q, count_d;

    logic                 abort;
    logic                 valid;
    logic                 pop;
    logic                 push;
    logic [2:0]           outstanding;
    logic                 issue;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        return (a == AW'(Depth - 1)) ? '0 : a + AW'(1);
    endfunction

`ifdef BRAM_READER_ABORT_EN
    assign abort = abort_i && (state_q != IDLE);
`else
    assign abort = 1'b0;
`endif

    assign valid = (count_q != 2'd0);
    assign pop   = valid && ready_i;
    assign push  = inflight_q && !abort;

    // Words already owed to the FIFO, crediting this cycle's pop so a full
    // pipeline can still sustain one read per cycle without overflowing.
    assign outstanding = 3'(count_q) + 3'(issued_q) + 3'(inflight_q) - 3'(pop);
    assign issue       = (state_q == RUN) && (issue_left_q != '0) &&
                         (outstanding < 3'd3) && !abort;

    // Next-state: burst sequencing, address generation, FIFO bookkeeping.
    // The start edge itself presents the first read so data lands at edge 2.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        out_left_d   = out_left_q;
        issued_d     = 1'b0;
        inflight_d   = issued_q;
        done_d       = 1'b0;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q + 2'(push) - 2'(pop);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (length_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d      = RUN;
                        addr_d       = base_addr_i;
                        issued_d     = 1'b1;
                        issue_left_d = length_i - (AW+1)'(1);
                        out_left_d   = length_i;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d       = addr_inc(addr_q);
                    issued_d     = 1'b1;
                    issue_left_d = issue_left_q - (AW+1)'(1);
                end
                if (issue_left_d == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d   = ptr_inc(rd_ptr_q);
            out_left_d = out_left_q - (AW+1)'(1);
            if (out_left_q == (AW+1)'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        if (abort) begin
            state_d      = IDLE;
            issue_left_d = '0;
            out_left_d   = '0;
            issued_d     = 1'b0;
            inflight_d   = 1'b0;
            done_d       = 1'b1;
            rd_ptr_d     = 2'd0;
            wr_ptr_d     = 2'd0;
            count_d      = 2'd0;
        end
    end

    // Control state registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            issue_left_q <= '0;
            out_left_q   <= '0;
            issued_q     <= 1'b0;
            inflight_q   <= 1'b0;
            done_q       <= 1'b0;
            rd_ptr_q     <= 2'd0;
            wr_ptr_q     <= 2'd0;
            count_q      <= 2'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            out_left_q   <= out_left_d;
            issued_q     <= issued_d;
            inflight_q   <= inflight_d;
            done_q       <= done_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage; a push into a full FIFO during a pop reuses the head slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 3; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push) begin
            fifo_q[wr_ptr_q] <= mem_data_i;
        end
    end

    assign mem_addr_o     = addr_q;
    assign mem_write_en_o = 1'b0;
    assign valid_o        = valid;
    assign data_o         = valid ? fifo_q[rd_ptr_q] : '0;
    assign last_o         = valid && (out_left_q == (AW+1)'(1));
    assign busy_o         = (state_q != IDLE);
    assign done_o         = done_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb/tb_bram_stream_reader.sv - scoreboard bench for bram_stream_reader (Depth 16, mem[i] = 0xA0 + i)
module tb_bram_stream_reader;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [AW:0]   length_i;
    logic [AW-1:0] mem_addr_o;
    logic          mem_write_en_o;
    logic [DW-1:0] mem_data_i;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
    logic          last_o;
    logic          busy_o;
    logic          done_o;
`ifdef BRAM_READER_ABORT_EN
    logic          abort_i;
`endif

    bram_stream_reader #(.DataWidth(DW), .Depth(DEPTH)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .base_addr_i    (base_addr_i),
        .length_i       (length_i),
        .mem_addr_o     (mem_addr_o),
        .mem_write_en_o (mem_write_en_o),
        .mem_data_i     (mem_data_i),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .last_o         (last_o),
        .busy_o         (busy_o),
`ifdef BRAM_READER_ABORT_EN
        .abort_i        (abort_i),
`endif
        .done_o         (done_o)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:DEPTH-1];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'hA0 + i);
        mem_data_i = '0;
    end
    always @(posedge clk) mem_data_i <= mem[mem_addr_o[3:0]];

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   xfer_cnt = 0;
    logic allow_done = 1'b0;
    logic rdy_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_word(input logic [DW-1:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic start_burst(input logic [AW-1:0] base, input logic [AW:0] len);
        @(negedge clk);
        start_i     = 1'b1;
        base_addr_i = base;
        length_i    = len;
        @(posedge clk);
        #1 start_i  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic ok;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !busy_o) break;
        end
        ok = (exp_q.size() == 0) && !busy_o;
        chk(name, 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_xfers(input int n);
        int base_cnt;
        base_cnt = xfer_cnt;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (xfer_cnt - base_cnt >= n) break;
        end
        chk("xfer_wait", 32'(xfer_cnt - base_cnt >= n), 32'd1);
    endtask

    // Ready driver: constant high, or the 1,0,0,1,0,1 stall pattern.
    initial begin
        logic [5:0] pat;
        int         pidx;
        pat     = 6'b101001;
        pidx    = 0;
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) begin
                ready_i = pat[pidx];
                pidx    = (pidx + 1) % 6;
            end else begin
                ready_i = 1'b1;
                pidx    = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every transfer, checks stall stability and done timing.
    initial begin
        logic          held;
        logic [DW-1:0] held_d;
        logic          done_exp;
        exp_t          e;
        held     = 1'b0;
        held_d   = '0;
        done_exp = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                held     = 1'b0;
                done_exp = 1'b0;
            end else begin
                if (done_exp) chk("done_pulse", 32'(done_o), 32'd1);
                else if (done_o && !allow_done) chk("spurious_done", 32'(done_o), 32'd0);
                done_exp = 1'b0;
                if (held) chk("stall_stable", {23'd0, valid_o, data_o}, {23'd0, 1'b1, held_d});
                if (valid_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", 32'(valid_o), 32'd0);
                    end else if (ready_i) begin
                        e = exp_q.pop_front();
                        chk("data", 32'(data_o), 32'(e.d));
                        chk("last", 32'(last_o), 32'(e.l));
                        xfer_cnt++;
                        done_exp = e.l;
                    end
                end
                held   = valid_o && !ready_i;
                held_d = data_o;
            end
        end
    end

    initial begin
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        base_addr_i = '0;
        length_i    = '0;
`ifdef BRAM_READER_ABORT_EN
        abort_i     = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset_outputs", {valid_o, last_o, busy_o, done_o, mem_write_en_o, 3'b0, data_o, 3'b0, mem_addr_o},
            32'd0);
        #1 rst_ni = 1'b1;
        @(negedge clk);

        // base 10 length 4: latency 3, address presented in cycle 1
        exp_word(8'hAA, 0); exp_word(8'hAB, 0); exp_word(8'hAC, 0); exp_word(8'hAD, 1);
        start_burst(5'd10, 6'd4);
        begin
            int cyc;
            for (cyc = 1; cyc <= 10; cyc++) begin
                @(negedge clk);
                if (cyc == 1) chk("addr_cycle1", 32'(mem_addr_o), 32'd10);
                if (valid_o) break;
            end
            chk("first_valid_latency", 32'(cyc), 32'd3);
        end
        wait_done("burst_base10");

        // wrap across Depth-1 -> 0
        exp_word(8'hAE, 0); exp_word(8'hAF, 0); exp_word(8'hA0, 0); exp_word(8'hA1, 1);
        start_burst(5'd14, 6'd4);
        wait_done("burst_wrap");

        // length 0: no read, no word, done next cycle; address stays at 1
        allow_done = 1'b1;
        start_burst(5'd7, 6'd0);
        @(negedge clk);
        chk("len0_done", 32'(done_o), 32'd1);
        chk("len0_novalid", 32'(valid_o), 32'd0);
        chk("len0_addr", 32'(mem_addr_o), 32'd1);
        @(negedge clk);
        chk("len0_done_once", {30'd0, done_o, busy_o}, 32'd0);
        allow_done = 1'b0;

        // length 1 at the top address
        exp_word(8'hAF, 1);
        start_burst(5'd15, 6'd1);
        wait_done("burst_len1");

        // length 8 with ready pattern 1,0,0,1,0,1
        rdy_mode = 1'b1;
        for (int i = 0; i < 8; i++) exp_word(8'(8'hA3 + i), i == 7);
        start_burst(5'd3, 6'd8);
        wait_done("burst_stall");
        rdy_mode = 1'b0;
        repeat (2) @(negedge clk);

        // reset after 3 of 6 words
        for (int i = 0; i < 6; i++) exp_word(8'(8'hA4 + i), i == 5);
        start_burst(5'd4, 6'd6);
        wait_xfers(3);
        @(posedge clk);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_reset_outputs", {valid_o, last_o, busy_o, done_o, 4'b0, data_o, 3'b0, mem_addr_o}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        #1 rst_ni = 1'b1;
        exp_word(8'hA0, 0); exp_word(8'hA1, 1);
        start_burst(5'd0, 6'd2);
        wait_done("burst_after_reset");

`ifdef BRAM_READER_ABORT_EN
        for (int i = 0; i < 8; i++) exp_word(8'(8'hA5 + i), i == 7);
        start_burst(5'd5, 6'd8);
        wait_xfers(2);
        allow_done = 1'b1;
        abort_i    = 1'b1;
        @(posedge clk);
        #1 abort_i = 1'b0;
        exp_q.delete();
        @(negedge clk);
        #1;
        chk("abort_done", 32'(done_o), 32'd1);
        chk("abort_idle", {30'd0, valid_o, busy_o}, 32'd0);
        allow_done = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_no_words", 32'(valid_o), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
